fp_significand_adder: RTL and testbench
=======================================

Name: fp_significand_adder

Overview:
Parametrised successor of the FP execute stage-3 significand adder. Per lane, it adds or subtracts aligned significands, applies rounding via carry-in, and converts between signed-magnitude and two's complement for float-to-int. It generalises lane count, significand width and pipeline depth, and adds a selectable IEEE rounding mode and valid/ready backpressure. It sits between the FP align stage and the FP normalise stage.

Parameters:
NUM_LANES, 16, number of independent vector lanes
SIG_WIDTH, 32, significand/sum width in bits
PIPE_DEPTH, 1, register stages from input to output, legal range 1..3

Ports:
clk  input  1  clock
reset  input  1  reset
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept a beat this cycle
in_mask  input  NUM_LANES  lane enable mask, passed through
in_is_ftoi  input  1  beat is a float-to-int conversion
in_round_mode  input  2  0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf)
in_sig_le  input  NUM_LANES*SIG_WIDTH  larger-exponent significand, per lane
in_sig_se  input  NUM_LANES*SIG_WIDTH  smaller-exponent aligned significand, per lane
in_logical_sub  input  NUM_LANES  per-lane subtract / two's-complement convert
in_sign  input  NUM_LANES  per-lane result sign
in_guard, in_round, in_sticky  input  NUM_LANES each  per-lane rounding bits
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_mask  output  NUM_LANES  registered in_mask
out_sum  output  NUM_LANES*SIG_WIDTH  unnormalised sum, per lane
out_carry  output  NUM_LANES  carry-out of the sum, per lane
out_sign  output  NUM_LANES  registered in_sign
out_logical_sub  output  NUM_LANES  registered in_logical_sub
out_inexact  output  NUM_LANES  inexact flag (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high on clk; all stage valid bits are cleared. out_valid=0 during and after reset. in_ready=1 once reset deasserts. Data registers are not reset.
- Arithmetic happens combinationally at input and is captured into stage 0. Stages 1..PIPE_DEPTH-1 are pure delay. out_* are driven from the last stage.
- Per lane:
  - odd = le[0]^se[0]
  - any = g|r|s
  - RNE: rnd = g&(r|s) | odd&g&!r&!s
  - RTZ: rnd = 0
  - RUP: rnd = any&!sign
  - RDN: rnd = any&sign
  - carry_in = logical_sub ^ (rnd & !is_ftoi)
  - {carry, sum} = le + (se ^ {SIG_WIDTH{logical_sub}}) + carry_in, computed at SIG_WIDTH+1 bits
- Lanes with mask=0 are still computed; the mask is only passed through.
- Handshake:
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready=1 or out_valid=0.
  - in_ready = stage 0 advances (combinational from out_ready through the chain). A beat transfers when in_valid & in_ready.
  - Bubbles collapse: an empty stage accepts data even while downstream stalls.
- With no stall, latency is exactly PIPE_DEPTH cycles and throughput is 1 beat per cycle.
- While stalled, all out_* hold stable. A beat is never dropped or duplicated.
- Simultaneous input accept and output drain on a full pipe is allowed (steady state).
- Reset mid-operation discards all in-flight beats, with no partial output.

Optional Feature:
- Macro: FP_ADD_INEXACT_EN.
- Defined: out_inexact[i] = registered (g|r|s) & !is_ftoi & mask[i], pipelined alongside the sum.
- Undefined: the out_inexact port remains and is tied to 0, and no registers are instantiated for it.

Test Plan:
1. RNE tie, even: le=0x00800000, se=0x00000002, sub=0, g=1, r=0, s=0 -> sum 0x00800002, carry 0.
2. RNE tie, odd: le=0x00800000, se=0x00000001, sub=0, g=1, r=0, s=0 -> sum 0x00800002. Same stimulus with RTZ -> 0x00800001.
3. Subtract with round: le=0x00C00000, se=0x00400000, sub=1, RNE, g=1, s=1 -> sum 0x007FFFFF. Same stimulus with RDN and sign=0 -> 0x00800000.
4. FTOI negate: is_ftoi=1, le=0, se=0x00000005, sub=1, g=1, r=1, RUP -> sum 0xFFFFFFFB, inexact 0.
5. Backpressure, PIPE_DEPTH=3: stream 6 beats, hold out_ready=0 for 4 cycles mid-stream -> in_ready drops after 3 held beats, outputs stay stable, all 6 sums emerge in order with none lost.
6. Assert reset with 2 beats in flight -> out_valid=0 immediately; after release, a new beat appears after 3 cycles, with no stale beats.

Source files
------------

// File: rtl/fp_significand_adder.sv
// Purpose: per-lane aligned significand add/subtract with carry-in rounding and
//          float-to-int two's-complement conversion, between FP align and normalise.
// Latency: PIPE_DEPTH cycles (legal 1..3); backpressure: valid/ready, bubbles collapse, outputs hold while stalled.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset (clears stage valids only)
//   in_valid / in_ready    input beat handshake (in_ready is combinational from out_ready)
//   in_mask                lane enable mask, passed through untouched
//   in_is_ftoi             beat is a float-to-int conversion (suppresses rounding increment)
//   in_round_mode          0=RNE 1=RTZ 2=RUP 3=RDN
//   in_sig_le, in_sig_se   per-lane larger-exponent and aligned smaller-exponent significands
//   in_logical_sub         per-lane subtract / two's-complement convert
//   in_sign                per-lane result sign
//   in_guard/round/sticky  per-lane rounding bits
//   out_valid / out_ready  output beat handshake
//   out_mask, out_sign, out_logical_sub   delayed copies of the inputs
//   out_sum, out_carry     per-lane unnormalised sum and carry-out
//   out_inexact            per-lane inexact flag
//
// Build option: define FP_ADD_INEXACT_EN to register and drive out_inexact;
// otherwise out_inexact is tied to zero and no flops exist for it.

module fp_significand_adder #(
    parameter int NUM_LANES  = 16,
    parameter int SIG_WIDTH  = 32,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES-1:0]           in_mask,
    input  logic                           in_is_ftoi,
    input  logic [1:0]                     in_round_mode,
    input  logic [NUM_LANES*SIG_WIDTH-1:0] in_sig_le,
    input  logic [NUM_LANES*SIG_WIDTH-1:0] in_sig_se,
    input  logic [NUM_LANES-1:0]           in_logical_sub,
    input  logic [NUM_LANES-1:0]           in_sign,
    input  logic [NUM_LANES-1:0]           in_guard,
    input  logic [NUM_LANES-1:0]           in_round,
    input  logic [NUM_LANES-1:0]           in_sticky,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES-1:0]           out_mask,
    output logic [NUM_LANES*SIG_WIDTH-1:0] out_sum,
    output logic [NUM_LANES-1:0]           out_carry,
    output logic [NUM_LANES-1:0]           out_sign,
    output logic [NUM_LANES-1:0]           out_logical_sub,
    output logic [NUM_LANES-1:0]           out_inexact
);

    localparam int LAST = PIPE_DEPTH - 1;

    typedef struct packed {
        logic [NUM_LANES-1:0]                mask;
        logic [NUM_LANES-1:0][SIG_WIDTH-1:0] sum;
        logic [NUM_LANES-1:0]                carry;
        logic [NUM_LANES-1:0]                sign;
        logic [NUM_LANES-1:0]                logical_sub;
`ifdef FP_ADD_INEXACT_EN
        logic [NUM_LANES-1:0]                inexact;
`endif
    } stage_t;

    logic [NUM_LANES-1:0][SIG_WIDTH-1:0] sum_d;
    logic [NUM_LANES-1:0]                carry_d;
`ifdef FP_ADD_INEXACT_EN
    logic [NUM_LANES-1:0]                inexact_d;
`endif

    stage_t                stg_d;
    stage_t                stg_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] vld_q;
    logic [PIPE_DEPTH-1:0] adv;

    // ------------------------------------------------------------------
    // Per-lane arithmetic, all combinational ahead of stage 0.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [SIG_WIDTH-1:0] le;
        logic [SIG_WIDTH-1:0] se;
        logic                 odd;
        logic                 any;
        logic                 rnd;
        logic                 cin;
        logic [SIG_WIDTH:0]   full;

        assign le  = in_sig_le[l*SIG_WIDTH +: SIG_WIDTH];
        assign se  = in_sig_se[l*SIG_WIDTH +: SIG_WIDTH];
        // Parity of the sum LSB, used to break RNE ties toward even.
        assign odd = le[0] ^ se[0];
        assign any = in_guard[l] | in_round[l] | in_sticky[l];

        always_comb begin
            rnd = 1'b0;
            case (in_round_mode)
                2'd0:    rnd = (in_guard[l] & (in_round[l] | in_sticky[l]))
                             | (odd & in_guard[l] & ~in_round[l] & ~in_sticky[l]);
                2'd1:    rnd = 1'b0;
                2'd2:    rnd = any & ~in_sign[l];
                default: rnd = any & in_sign[l];
            endcase
        end

        // Subtraction is le + ~se + 1; a rounding increment cancels that +1,
        // which is why the two terms are XORed rather than summed.
        assign cin  = in_logical_sub[l] ^ (rnd & ~in_is_ftoi);
        assign full = {1'b0, le}
                    + {1'b0, se ^ {SIG_WIDTH{in_logical_sub[l]}}}
                    + {{SIG_WIDTH{1'b0}}, cin};

        assign sum_d[l]   = full[SIG_WIDTH-1:0];
        assign carry_d[l] = full[SIG_WIDTH];
`ifdef FP_ADD_INEXACT_EN
        assign inexact_d[l] = any & ~in_is_ftoi & in_mask[l];
`endif
    end

    always_comb begin
        stg_d             = '0;
        stg_d.mask        = in_mask;
        stg_d.sum         = sum_d;
        stg_d.carry       = carry_d;
        stg_d.sign        = in_sign;
        stg_d.logical_sub = in_logical_sub;
`ifdef FP_ADD_INEXACT_EN
        stg_d.inexact     = inexact_d;
`endif
    end

    // ------------------------------------------------------------------
    // Handshake: stage k may load when any stage from k to the output is
    // empty, or the output is being drained. This is the unrolled form of
    // "empty or next stage advances" and avoids a bit-to-bit comb chain.
    // ------------------------------------------------------------------
    always_comb begin
        adv = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            adv[k] = out_ready | ~&(vld_q | ~({PIPE_DEPTH{1'b1}} << k));
        end
    end

    assign in_ready = adv[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            if (adv[0]) begin
                vld_q[0] <= in_valid;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end
    end

    // Data flops carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (adv[0]) begin
            stg_q[0] <= stg_d;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (adv[k]) begin
                stg_q[k] <= stg_q[k-1];
            end
        end
    end

    assign out_valid       = vld_q[LAST];
    assign out_mask        = stg_q[LAST].mask;
    assign out_sum         = stg_q[LAST].sum;
    assign out_carry       = stg_q[LAST].carry;
    assign out_sign        = stg_q[LAST].sign;
    assign out_logical_sub = stg_q[LAST].logical_sub;
`ifdef FP_ADD_INEXACT_EN
    assign out_inexact     = stg_q[LAST].inexact;
`else
    assign out_inexact     = '0;
`endif

endmodule

// File: tb/tb_fp_significand_adder.sv
// Purpose: self-checking bench for fp_significand_adder (4 lanes, 32-bit, 3 stages).
// Latency: expects exactly 3 cycles for unstalled beats, at least 3 otherwise.
// Backpressure: exercises output stalls, full-pipe blocking and reset flush.

module tb_fp_significand_adder;

    localparam int NL = 4;
    localparam int W  = 32;
    localparam int PD = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NL-1:0]     in_mask = '0;
    logic              in_is_ftoi = 1'b0;
    logic [1:0]        in_round_mode = '0;
    logic [NL*W-1:0]   in_sig_le = '0;
    logic [NL*W-1:0]   in_sig_se = '0;
    logic [NL-1:0]     in_logical_sub = '0;
    logic [NL-1:0]     in_sign = '0;
    logic [NL-1:0]     in_guard = '0;
    logic [NL-1:0]     in_round = '0;
    logic [NL-1:0]     in_sticky = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [NL-1:0]     out_mask;
    logic [NL*W-1:0]   out_sum;
    logic [NL-1:0]     out_carry;
    logic [NL-1:0]     out_sign;
    logic [NL-1:0]     out_logical_sub;
    logic [NL-1:0]     out_inexact;

    fp_significand_adder #(
        .NUM_LANES  (NL),
        .SIG_WIDTH  (W),
        .PIPE_DEPTH (PD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_mask         (in_mask),
        .in_is_ftoi      (in_is_ftoi),
        .in_round_mode   (in_round_mode),
        .in_sig_le       (in_sig_le),
        .in_sig_se       (in_sig_se),
        .in_logical_sub  (in_logical_sub),
        .in_sign         (in_sign),
        .in_guard        (in_guard),
        .in_round        (in_round),
        .in_sticky       (in_sticky),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_mask        (out_mask),
        .out_sum         (out_sum),
        .out_carry       (out_carry),
        .out_sign        (out_sign),
        .out_logical_sub (out_logical_sub),
        .out_inexact     (out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0]        mask;
        logic                 ftoi;
        logic [1:0]           mode;
        logic [NL-1:0][W-1:0] le;
        logic [NL-1:0][W-1:0] se;
        logic [NL-1:0]        sub;
        logic [NL-1:0]        sign;
        logic [NL-1:0]        g;
        logic [NL-1:0]        r;
        logic [NL-1:0]        s;
    } beat_t;

    typedef struct {
        logic [NL-1:0][W-1:0] sum;
        logic [NL-1:0]        carry;
        logic [NL-1:0]        mask;
        logic [NL-1:0]        sign;
        logic [NL-1:0]        sub;
        logic [NL-1:0]        inexact;
        int                   acc;
        bit                   lat_exact;
        bit                   lit_vld;
        logic [W-1:0]         lit_sum;
        logic                 lit_carry;
    } exp_t;

    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: arithmetic meaning of the operation rather than its
    // adder construction. Addition adds the increment; subtraction is
    // 2^W + le - se - increment, whose top bit is the no-borrow carry.
    function automatic exp_t model(input beat_t b);
        exp_t e;
        e = '{default: '0};
        for (int i = 0; i < NL; i++) begin
            bit          odd;
            bit          any;
            bit          up;
            bit          inc;
            logic [W:0]  exact;
            odd = b.le[i][0] ^ b.se[i][0];
            any = b.g[i] || b.r[i] || b.s[i];
            case (b.mode)
                2'd0:    up = b.g[i] && (b.r[i] || b.s[i] || odd);
                2'd1:    up = 1'b0;
                2'd2:    up = any && !b.sign[i];
                default: up = any && b.sign[i];
            endcase
            inc = b.ftoi ? 1'b0 : up;
            if (b.sub[i])
                exact = {1'b1, {W{1'b0}}} + {1'b0, b.le[i]} - {1'b0, b.se[i]} - (W+1)'(inc);
            else
                exact = {1'b0, b.le[i]} + {1'b0, b.se[i]} + (W+1)'(inc);
            e.sum[i]   = exact[W-1:0];
            e.carry[i] = exact[W];
`ifdef FP_ADD_INEXACT_EN
            e.inexact[i] = any && !b.ftoi && b.mask[i];
`else
            e.inexact[i] = 1'b0;
`endif
        end
        e.mask = b.mask;
        e.sign = b.sign;
        e.sub  = b.sub;
        return e;
    endfunction

    function automatic beat_t mk(input logic [W-1:0] le0, input logic [W-1:0] se0,
                                 input bit sub0, input bit sign0, input bit g0, input bit r0,
                                 input bit s0, input logic [1:0] mode, input bit ftoi);
        beat_t b;
        b.mask = NL'($urandom);
        b.ftoi = ftoi;
        b.mode = mode;
        for (int i = 0; i < NL; i++) begin
            b.le[i]   = $urandom;
            b.se[i]   = $urandom;
            b.sub[i]  = 1'($urandom);
            b.sign[i] = 1'($urandom);
            b.g[i]    = 1'($urandom);
            b.r[i]    = 1'($urandom);
            b.s[i]    = 1'($urandom);
        end
        b.mask[0] = 1'b1;
        b.le[0]   = le0;
        b.se[0]   = se0;
        b.sub[0]  = sub0;
        b.sign[0] = sign0;
        b.g[0]    = g0;
        b.r[0]    = r0;
        b.s[0]    = s0;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        return mk($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    endfunction

    task automatic apply(input beat_t b);
        in_mask        = b.mask;
        in_is_ftoi     = b.ftoi;
        in_round_mode  = b.mode;
        in_sig_le      = b.le;
        in_sig_se      = b.se;
        in_logical_sub = b.sub;
        in_sign        = b.sign;
        in_guard       = b.g;
        in_round       = b.r;
        in_sticky      = b.s;
    endtask

    // Presents a beat and returns on the negedge at which it is accepted;
    // the transfer itself happens at the following posedge.
    task automatic send(input beat_t b, input bit lat_exact, input bit lit_vld,
                        input logic [W-1:0] lit_sum, input logic lit_carry);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        apply(b);
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                return;
            end
        end
        e           = model(b);
        e.acc       = cyc;
        e.lat_exact = lat_exact;
        e.lit_vld   = lit_vld;
        e.lit_sum   = lit_sum;
        e.lit_carry = lit_carry;
        expq.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    // Compare process: every negedge, outputs are checked against the model queue.
    logic [NL*W-1:0] snap_sum;
    logic [NL-1:0]   snap_carry, snap_mask, snap_sign, snap_sub, snap_inx;
    bit              hold = 1'b0;
    exp_t            pe;

    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
            chk("reset_out_valid", 64'(out_valid), 64'd0);
        end else begin
            if (hold) begin
                chk("stall_stable", 64'(out_valid && out_sum == snap_sum && out_carry == snap_carry
                                        && out_mask == snap_mask && out_sign == snap_sign
                                        && out_logical_sub == snap_sub && out_inexact == snap_inx),
                    64'd1);
            end
            hold       = out_valid && !out_ready;
            snap_sum   = out_sum;
            snap_carry = out_carry;
            snap_mask  = out_mask;
            snap_sign  = out_sign;
            snap_sub   = out_logical_sub;
            snap_inx   = out_inexact;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got out_valid=1 sum0=%h required no beat (cycle %0d)",
                             out_sum[W-1:0], cyc);
                end else begin
                    pe = expq.pop_front();
                    for (int i = 0; i < NL; i++) begin
                        chk($sformatf("sum_lane%0d", i), 64'(out_sum[i*W +: W]), 64'(pe.sum[i]));
                    end
                    chk("carry",       64'(out_carry),       64'(pe.carry));
                    chk("mask",        64'(out_mask),        64'(pe.mask));
                    chk("sign",        64'(out_sign),        64'(pe.sign));
                    chk("logical_sub", 64'(out_logical_sub), 64'(pe.sub));
                    chk("inexact",     64'(out_inexact),     64'(pe.inexact));
                    if (pe.lat_exact)
                        chk("latency", 64'(cyc - pe.acc), 64'(PD));
                    else
                        chk("latency_min", 64'(cyc - pe.acc >= PD), 64'd1);
                    if (pe.lit_vld) begin
                        chk("literal_sum0",   64'(out_sum[W-1:0]), 64'(pe.lit_sum));
                        chk("literal_carry0", 64'(out_carry[0]),   64'(pe.lit_carry));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",    64'(in_ready),  64'd1);
        chk("reset_valid_after", 64'(out_valid), 64'd0);

        // RNE tie, even and odd; RTZ truncation.
        send(mk(32'h0080_0000, 32'h0000_0002, 0, 0, 1, 0, 0, 2'd0, 0), 1, 1, 32'h0080_0002, 1'b0);
        idle(); drain();
        send(mk(32'h0080_0000, 32'h0000_0001, 0, 0, 1, 0, 0, 2'd0, 0), 1, 1, 32'h0080_0002, 1'b0);
        idle(); drain();
        send(mk(32'h0080_0000, 32'h0000_0001, 0, 0, 1, 0, 0, 2'd1, 0), 1, 1, 32'h0080_0001, 1'b0);
        idle(); drain();
        // Subtract with rounding increment (RNE) and without (RDN, positive).
        send(mk(32'h00C0_0000, 32'h0040_0000, 1, 0, 1, 0, 1, 2'd0, 0), 1, 1, 32'h007F_FFFF, 1'b1);
        idle(); drain();
        send(mk(32'h00C0_0000, 32'h0040_0000, 1, 0, 1, 0, 1, 2'd3, 0), 1, 1, 32'h0080_0000, 1'b1);
        idle(); drain();
        // Float-to-int negate: rounding suppressed.
        send(mk(32'h0000_0000, 32'h0000_0005, 1, 0, 1, 1, 0, 2'd2, 1), 1, 1, 32'hFFFF_FFFB, 1'b0);
        idle(); drain();
        // RUP on a negative lane must not increment; on a positive lane it must.
        send(mk(32'h0000_1000, 32'h0000_0010, 0, 1, 0, 0, 1, 2'd2, 0), 1, 1, 32'h0000_1010, 1'b0);
        idle(); drain();
        send(mk(32'h0000_1000, 32'h0000_0010, 0, 0, 0, 0, 1, 2'd2, 0), 1, 1, 32'h0000_1011, 1'b0);
        idle(); drain();
        // Carry-out on overflow of an add.
        send(mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 0, 2'd1, 0), 1, 1, 32'h0000_0000, 1'b1);
        idle(); drain();

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 20; i++) send(rnd_beat(), 1, 0, '0, 1'b0);
        idle(); drain();

        // Output stall mid-stream: pipe fills to three beats and blocks input.
        fork
            begin
                for (int i = 0; i < 6; i++) send(rnd_beat(), 0, 0, '0, 1'b0);
                idle();
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                chk("bp_in_ready",  64'(in_ready),     64'd0);
                chk("bp_out_valid", 64'(out_valid),    64'd1);
                chk("bp_inflight",  64'(expq.size()),  64'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        send(rnd_beat(), 0, 0, '0, 1'b0);
        send(rnd_beat(), 0, 0, '0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        chk("flush_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        expq.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(mk(32'h0000_0100, 32'h0000_0023, 0, 0, 0, 0, 0, 2'd0, 0), 1, 1, 32'h0000_0123, 1'b0);
        idle(); drain();
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
